// File: rtl/ibex_pkg.sv
// Shared core types: interrupt layout, exception cause encoding and the
// interrupt arbiter's state encoding.
package ibex_pkg;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    typedef struct packed {
        logic       irq_ext;
        logic [4:0] lower_cause;
    } exc_cause_e;

    localparam exc_cause_e EXC_CAUSE_IRQ_SOFTWARE_M = '{irq_ext: 1'b1, lower_cause: 5'd3};
    localparam exc_cause_e EXC_CAUSE_IRQ_TIMER_M    = '{irq_ext: 1'b1, lower_cause: 5'd7};
    localparam exc_cause_e EXC_CAUSE_IRQ_EXTERNAL_M = '{irq_ext: 1'b1, lower_cause: 5'd11};
    localparam exc_cause_e EXC_CAUSE_IRQ_FAST_BASE  = '{irq_ext: 1'b1, lower_cause: 5'd16};
    localparam exc_cause_e EXC_CAUSE_IRQ_NM         = '{irq_ext: 1'b1, lower_cause: 5'd31};

    typedef enum logic [1:0] {
        IRQ_ARB_IDLE,
        IRQ_ARB_OFFER,
        IRQ_ARB_GAP
    } irq_arb_state_e;

    function automatic exc_cause_e irq_fast_cause(input logic [3:0] idx);
        return '{irq_ext: 1'b1,
                 lower_cause: EXC_CAUSE_IRQ_FAST_BASE.lower_cause + {1'b0, idx}};
    endfunction

endpackage

// File: rtl/ibex_irq_arbiter_if.sv
// Interrupt offer handshake between the arbiter (master) and the controller (slave).
interface ibex_irq_arbiter_if;
    import ibex_pkg::*;

    logic       irq_req;
    exc_cause_e irq_cause;
    logic       irq_ack;
    logic       mret;
    logic       nmi_mode;

    modport master (output irq_req, irq_cause, nmi_mode, input irq_ack, mret);
    modport slave  (input irq_req, irq_cause, nmi_mode, output irq_ack, mret);

endinterface

// File: rtl/ibex_irq_prio_enc.sv
// Combinational priority encoder: NMI > MEI > MSI > MTI > fast[0] .. fast[14].
module ibex_irq_prio_enc
    import ibex_pkg::*;
(
    input  irqs_t      eligible,
    input  logic       nmi,
    output logic       valid,
    output exc_cause_e cause
);

    // Lowest priority is assigned first so that later, higher-priority hits override it.
    always_comb begin
        valid = 1'b0;
        cause = '0;
        for (int unsigned i = 15; i > 0; i--) begin
            if (eligible.irq_fast[i-1]) begin
                valid = 1'b1;
                cause = irq_fast_cause(4'(i - 1));
            end
        end
        if (eligible.irq_timer) begin
            valid = 1'b1;
            cause = EXC_CAUSE_IRQ_TIMER_M;
        end
        if (eligible.irq_software) begin
            valid = 1'b1;
            cause = EXC_CAUSE_IRQ_SOFTWARE_M;
        end
        if (eligible.irq_external) begin
            valid = 1'b1;
            cause = EXC_CAUSE_IRQ_EXTERNAL_M;
        end
        if (nmi) begin
            valid = 1'b1;
            cause = EXC_CAUSE_IRQ_NM;
        end
    end

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Registers interrupt lines, captures NMI edges and offers the highest-priority
// eligible interrupt to the controller with a cause frozen until ack or withdrawal.
module ibex_irq_arbiter
    import ibex_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  irqs_t irqs_i,
    input  logic  irq_nm_i,
    input  irqs_t mie_i,
    input  logic  mstatus_mie_i,
    input  logic  debug_mode_i,
    output irqs_t mip_o,
    output logic  irq_pending_o,
    ibex_irq_arbiter_if.master ctrl
);

    irq_arb_state_e state_q;
    irqs_t          mip_q;
    logic           nm_q;
    logic           nmi_pend_q;
    logic           nmi_mode_q;
    exc_cause_e     cause_q;

    irqs_t      eligible;
    logic       nmi_eligible;
    logic       blocked;
    logic       win_valid;
    exc_cause_e win_cause;
    logic       latched_eligible;
    logic       nmi_ack;

    always_comb begin
        blocked      = nmi_mode_q | debug_mode_i;
        eligible     = (mstatus_mie_i && !blocked) ? (mip_q & mie_i) : '0;
        nmi_eligible = nmi_pend_q & ~blocked;
        nmi_ack      = (state_q == IRQ_ARB_OFFER) & ctrl.irq_ack & (cause_q == EXC_CAUSE_IRQ_NM);
    end

    // Map the frozen cause back to its source; an offered NMI is never withdrawn.
    always_comb begin
        latched_eligible = 1'b0;
        if (cause_q == EXC_CAUSE_IRQ_NM) begin
            latched_eligible = 1'b1;
        end else if (cause_q == EXC_CAUSE_IRQ_EXTERNAL_M) begin
            latched_eligible = eligible.irq_external;
        end else if (cause_q == EXC_CAUSE_IRQ_SOFTWARE_M) begin
            latched_eligible = eligible.irq_software;
        end else if (cause_q == EXC_CAUSE_IRQ_TIMER_M) begin
            latched_eligible = eligible.irq_timer;
        end else if (cause_q.lower_cause[4]) begin
            latched_eligible = eligible.irq_fast[cause_q.lower_cause[3:0]];
        end
    end

    ibex_irq_prio_enc u_prio_enc (
        .eligible (eligible),
        .nmi      (nmi_eligible),
        .valid    (win_valid),
        .cause    (win_cause)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IRQ_ARB_IDLE;
            mip_q      <= '0;
            nm_q       <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_mode_q <= 1'b0;
            cause_q    <= '0;
        end else begin
            mip_q      <= irqs_i;
            nm_q       <= irq_nm_i;
            // A new edge in the ack cycle keeps the NMI pending.
            nmi_pend_q <= (irq_nm_i & ~nm_q) | (nmi_pend_q & ~nmi_ack);
            nmi_mode_q <= (nmi_mode_q & ~ctrl.mret) | nmi_ack;
            case (state_q)
                IRQ_ARB_IDLE: begin
                    if (win_valid) begin
                        state_q <= IRQ_ARB_OFFER;
                        cause_q <= win_cause;
                    end
                end
                IRQ_ARB_OFFER: begin
                    if (ctrl.irq_ack) begin
                        state_q <= IRQ_ARB_GAP;
                    end else if (!latched_eligible) begin
                        state_q <= IRQ_ARB_IDLE;
                    end
                end
                IRQ_ARB_GAP: state_q <= IRQ_ARB_IDLE;
                default:     state_q <= IRQ_ARB_IDLE;
            endcase
        end
    end

    assign mip_o          = mip_q;
    assign irq_pending_o  = (|(mip_q & mie_i)) | nmi_pend_q;
    assign ctrl.irq_req   = (state_q == IRQ_ARB_OFFER);
    assign ctrl.irq_cause = cause_q;
    assign ctrl.nmi_mode  = nmi_mode_q;

    ack_only_in_offer: assert property (@(posedge clk_i) disable iff (rst_i)
        ctrl.irq_ack |-> state_q == IRQ_ARB_OFFER);

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Bench for ibex_irq_arbiter: directed vector table, an NMI corner sequence and
// randomized traffic against a behavioural model.
module tb_ibex_irq_arbiter;
    import ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] irqs_v;
    logic        nm;
    logic [17:0] mie_v;
    logic        gmie;
    logic        dbg;
    irqs_t       mip;
    logic        pend_o;
    logic [5:0]  cause_w;
    logic [17:0] mip_w;

    ibex_irq_arbiter_if ctrl ();

    ibex_irq_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .irqs_i        (irqs_v),
        .irq_nm_i      (nm),
        .mie_i         (mie_v),
        .mstatus_mie_i (gmie),
        .debug_mode_i  (dbg),
        .mip_o         (mip),
        .irq_pending_o (pend_o),
        .ctrl          (ctrl.master)
    );

    assign cause_w = ctrl.irq_cause;
    assign mip_w   = mip;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: sources listed in priority order with bit position and cause.
    int          src_bit[18];
    int          src_cause[18];
    logic [17:0] m_mip;
    bit          m_nm, m_pend, m_mode, m_offer, m_gap;
    int          m_cause;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit el[18];
        bit nmi_el, rise, clr, st;
        int win;
        if (rst) begin
            m_mip = '0; m_nm = 0; m_pend = 0; m_mode = 0;
            m_offer = 0; m_gap = 0; m_cause = 0;
            return;
        end
        for (int k = 0; k < 18; k++)
            el[k] = m_mip[src_bit[k]] && mie_v[src_bit[k]] && gmie && !m_mode && !dbg;
        nmi_el = m_pend && !m_mode && !dbg;
        rise   = nm && !m_nm;
        clr    = 0;
        if (m_offer) begin
            if (ctrl.irq_ack) begin
                m_offer = 0;
                m_gap   = 1;
                if (m_cause == 63) clr = 1;
            end else if (m_cause != 63) begin
                st = 0;
                for (int k = 0; k < 18; k++)
                    if (src_cause[k] == m_cause) st = el[k];
                if (!st) m_offer = 0;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            win = -1;
            if (nmi_el) win = 63;
            else
                for (int k = 0; k < 18; k++)
                    if (el[k] && win < 0) win = src_cause[k];
            if (win >= 0) begin
                m_offer = 1;
                m_cause = win;
            end
        end
        if (ctrl.mret) m_mode = 0;
        if (clr) m_mode = 1;
        m_pend = rise || (m_pend && !clr);
        m_mip  = irqs_v;
        m_nm   = nm;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_req",   int'(ctrl.irq_req),  int'(m_offer));
        chk("model_cause", int'(cause_w),       m_cause);
        chk("model_mode",  int'(ctrl.nmi_mode), int'(m_mode));
        chk("model_mip",   int'(mip_w),         int'(m_mip));
        chk("model_pend",  int'(pend_o),        int'((|(m_mip & mie_v)) || m_pend));
    endtask

    typedef struct {
        logic        rst;
        logic [17:0] irqs;
        logic        nm;
        logic [17:0] mie;
        logic        gmie, dbg, ack, mret;
        logic        e_req;
        logic [5:0]  e_cause;
        logic        e_mode, e_pend;
    } vec_t;

    function automatic vec_t v(logic r, logic [17:0] i, logic n, logic [17:0] m, logic g,
                               logic d, logic a, logic mr, logic er, logic [5:0] ec,
                               logic em, logic ep);
        vec_t x;
        x.rst = r; x.irqs = i; x.nm = n; x.mie = m; x.gmie = g; x.dbg = d;
        x.ack = a; x.mret = mr; x.e_req = er; x.e_cause = ec; x.e_mode = em; x.e_pend = ep;
        return x;
    endfunction

    localparam logic [17:0] A = 18'h3FFFF, T = 18'h10000, E = 18'h08000, NF0 = 18'h3FFFE;

    vec_t tbl[$];

    initial begin
        src_bit[0] = 15; src_cause[0] = 6'h2B;
        src_bit[1] = 17; src_cause[1] = 6'h23;
        src_bit[2] = 16; src_cause[2] = 6'h27;
        for (int i = 0; i < 15; i++) begin
            src_bit[3+i]   = i;
            src_cause[3+i] = 6'h30 + i;
        end
        rst = 1'b1; irqs_v = '0; nm = 1'b0; mie_v = '0; gmie = 1'b0; dbg = 1'b0;
        ctrl.irq_ack = 1'b0; ctrl.mret = 1'b0;

        //          rst irqs      nm mie  g  d  ak mr  req cause  mode pend
        tbl.push_back(v(1, 18'h0,     0, T,   1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, T,         0, T,   1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, T,         0, T,   1, 0, 0, 0,  1, 6'h27, 0, 1));
        tbl.push_back(v(0, T,         0, T,   1, 0, 0, 0,  1, 6'h27, 0, 1));
        tbl.push_back(v(0, 18'h0,     0, T,   1, 0, 1, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     0, T,   1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     0, T,   1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h30208, 0, A,   1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h30208, 0, A,   1, 0, 0, 0,  1, 6'h23, 0, 1));
        tbl.push_back(v(0, 18'h10208, 0, A,   1, 0, 1, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h10208, 0, A,   1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h10208, 0, A,   1, 0, 0, 0,  1, 6'h27, 0, 1));
        tbl.push_back(v(0, 18'h00208, 0, A,   1, 0, 1, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h00208, 0, A,   1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h00208, 0, A,   1, 0, 0, 0,  1, 6'h33, 0, 1));
        tbl.push_back(v(0, 18'h0,     0, A,   1, 0, 1, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     0, A,   1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     0, A,   1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h00020, 0, A,   1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h00020, 0, A,   1, 0, 0, 0,  1, 6'h35, 0, 1));
        tbl.push_back(v(0, 18'h08020, 0, A,   1, 0, 0, 0,  1, 6'h35, 0, 1));
        tbl.push_back(v(0, 18'h08020, 0, A,   1, 0, 0, 0,  1, 6'h35, 0, 1));
        tbl.push_back(v(0, E,         0, A,   1, 0, 1, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, E,         0, A,   1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, E,         0, A,   1, 0, 0, 0,  1, 6'h2B, 0, 1));
        tbl.push_back(v(0, 18'h0,     0, A,   1, 0, 1, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     0, A,   1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h00001, 0, A,   1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h00001, 0, A,   1, 0, 0, 0,  1, 6'h30, 0, 1));
        tbl.push_back(v(0, 18'h00001, 0, NF0, 1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h00001, 0, NF0, 1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h00001, 0, NF0, 1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     1, A,   0, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h0,     1, A,   0, 0, 0, 0,  1, 6'h3F, 0, 1));
        tbl.push_back(v(0, 18'h0,     0, A,   0, 0, 1, 0,  0, 6'h00, 1, 0));
        tbl.push_back(v(0, 18'h0,     0, A,   0, 0, 0, 0,  0, 6'h00, 1, 0));
        tbl.push_back(v(0, 18'h0,     1, A,   0, 0, 0, 0,  0, 6'h00, 1, 1));
        tbl.push_back(v(0, 18'h0,     0, A,   0, 0, 0, 0,  0, 6'h00, 1, 1));
        tbl.push_back(v(0, 18'h0,     0, A,   0, 0, 0, 1,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h0,     0, A,   0, 0, 0, 0,  1, 6'h3F, 0, 1));
        tbl.push_back(v(0, 18'h0,     0, A,   0, 0, 1, 0,  0, 6'h00, 1, 0));
        tbl.push_back(v(0, 18'h0,     0, A,   0, 0, 0, 1,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     0, A,   0, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, E,         0, A,   1, 1, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, E,         0, A,   1, 1, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, E,         0, A,   1, 1, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, E,         0, A,   1, 0, 0, 0,  1, 6'h2B, 0, 1));
        tbl.push_back(v(1, E,         0, A,   1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     0, A,   1, 0, 0, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h00003, 0, A,   1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h00003, 0, A,   1, 0, 0, 0,  1, 6'h30, 0, 1));
        tbl.push_back(v(0, 18'h00003, 0, NF0, 1, 0, 1, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h00003, 0, NF0, 1, 0, 0, 0,  0, 6'h00, 0, 1));
        tbl.push_back(v(0, 18'h00003, 0, NF0, 1, 0, 0, 0,  1, 6'h31, 0, 1));
        tbl.push_back(v(0, 18'h0,     0, A,   1, 0, 1, 0,  0, 6'h00, 0, 0));
        tbl.push_back(v(0, 18'h0,     0, A,   1, 0, 0, 0,  0, 6'h00, 0, 0));

        foreach (tbl[r]) begin
            rst = tbl[r].rst; irqs_v = tbl[r].irqs; nm = tbl[r].nm; mie_v = tbl[r].mie;
            gmie = tbl[r].gmie; dbg = tbl[r].dbg;
            ctrl.irq_ack = tbl[r].ack; ctrl.mret = tbl[r].mret;
            tick();
            chk($sformatf("row%0d_req", r),  int'(ctrl.irq_req),  int'(tbl[r].e_req));
            chk($sformatf("row%0d_mode", r), int'(ctrl.nmi_mode), int'(tbl[r].e_mode));
            chk($sformatf("row%0d_pend", r), int'(pend_o),        int'(tbl[r].e_pend));
            if (tbl[r].e_req || tbl[r].rst)
                chk($sformatf("row%0d_cause", r), int'(cause_w), int'(tbl[r].e_cause));
        end

        // NMI edge landing in the same cycle as the NMI ack stays pending.
        ctrl.irq_ack = 1'b0; ctrl.mret = 1'b0; irqs_v = '0; gmie = 1'b0; dbg = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        nm = 1'b1; tick();
        nm = 1'b0; tick();
        chk("nmi_seq_req", int'(ctrl.irq_req), 1);
        chk("nmi_seq_cause", int'(cause_w), 6'h3F);
        ctrl.irq_ack = 1'b1; nm = 1'b1; tick();
        ctrl.irq_ack = 1'b0;
        chk("nmi_seq_mode", int'(ctrl.nmi_mode), 1);
        chk("nmi_seq_pend_kept", int'(pend_o), 1);
        chk("nmi_seq_gap_req", int'(ctrl.irq_req), 0);
        nm = 1'b0; tick(); tick();
        chk("nmi_seq_blocked", int'(ctrl.irq_req), 0);
        ctrl.mret = 1'b1; tick(); ctrl.mret = 1'b0;
        chk("nmi_seq_mret_mode", int'(ctrl.nmi_mode), 0);
        chk("nmi_seq_mret_req", int'(ctrl.irq_req), 0);
        tick();
        chk("nmi_seq_reoffer", int'(ctrl.irq_req), 1);
        chk("nmi_seq_reoffer_cause", int'(cause_w), 6'h3F);
        ctrl.irq_ack = 1'b1; tick(); ctrl.irq_ack = 1'b0;
        ctrl.mret = 1'b1; tick(); ctrl.mret = 1'b0;

        // Randomized traffic; ack is only raised while the model is offering.
        mie_v = A; gmie = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 2) == 0) irqs_v[$urandom_range(0, 17)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) mie_v = 18'($urandom);
            else if ($urandom_range(0, 39) == 0) mie_v = '1;
            if ($urandom_range(0, 4) == 0) nm = ~nm;
            gmie = ($urandom_range(0, 7) != 0);
            dbg  = ($urandom_range(0, 24) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            ctrl.irq_ack = m_offer && ($urandom_range(0, 2) == 0);
            ctrl.mret    = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
